// File: rtl/router_port_arbiter.sv
// Round-robin arbiter and 4-phase handshake sequencer for one router output port.
// The grant is locked to one input from header flit to tail (EOP) flit.

module router_port_arbiter_lane #(
   parameter int GW  = 3,
   parameter int IDX = 0
) (
   input  logic [GW-1:0] g,
   input  logic          busy,
   input  logic          ack,
   output logic          grant,
   output logic          in_ack
);
   logic hit;

   assign hit    = busy && (g == GW'(IDX));
   assign grant  = hit;
   assign in_ack = hit && ack;
endmodule

module router_port_arbiter #(
   parameter int n    = 32,
   parameter int N_IN = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_IN-1:0]          in_req,
   input  logic [N_IN-1:0][n-1:0]   in_data,
   output logic [N_IN-1:0]          in_ack,
   output logic                     out_req,
   output logic [n-1:0]             out_data,
   input  logic                     out_ack,
   output logic [N_IN-1:0]          grant,
   output logic                     busy
);
   localparam int GW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic [GW:0] NIN = (GW+1)'(N_IN);

   typedef enum logic [2:0] {IDLE, SEND, ACKD, RTZ, HOLD} state_t;

   state_t         state, state_n;
   logic [GW-1:0]  g, g_n, ptr, ptr_n, sel;
   logic           eop, eop_n, ack, ack_n, req_n, any;
   logic [n-1:0]   data_n;
   logic [GW:0]    idx;

   // Rotating priority: first requester at or after ptr+1, wrapping modulo N_IN.
   always_comb begin
      sel = '0;
      any = 1'b0;
      idx = '0;
      for (int i = 1; i <= N_IN; i++) begin
         idx = {1'b0, ptr} + (GW+1)'(i);
         if (idx >= NIN) idx = idx - NIN;
         if (!any && in_req[idx[GW-1:0]]) begin
            any = 1'b1;
            sel = idx[GW-1:0];
         end
      end
   end

   always_comb begin
      state_n = state;
      g_n     = g;
      ptr_n   = ptr;
      eop_n   = eop;
      ack_n   = ack;
      req_n   = out_req;
      data_n  = out_data;
      case (state)
         IDLE: if (any) begin
            g_n     = sel;
            data_n  = in_data[sel];
            eop_n   = in_data[sel][n-1];
            req_n   = 1'b1;
            state_n = SEND;
         end
         SEND: if (out_ack) begin
            ack_n   = 1'b1;
            state_n = ACKD;
         end
         ACKD: if (!in_req[g]) begin
            req_n   = 1'b0;
            state_n = RTZ;
         end
         RTZ: if (!out_ack) begin
            ack_n = 1'b0;
            if (eop) begin
               ptr_n   = g;
               state_n = IDLE;
            end else begin
               state_n = HOLD;
            end
         end
         // Packet lock: only the owner's next flit is accepted here.
         HOLD: if (in_req[g]) begin
            data_n  = in_data[g];
            eop_n   = in_data[g][n-1];
            req_n   = 1'b1;
            state_n = SEND;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         g        <= '0;
         ptr      <= GW'(N_IN-1);
         eop      <= 1'b0;
         ack      <= 1'b0;
         out_req  <= 1'b0;
         out_data <= '0;
      end else begin
         state    <= state_n;
         g        <= g_n;
         ptr      <= ptr_n;
         eop      <= eop_n;
         ack      <= ack_n;
         out_req  <= req_n;
         out_data <= data_n;
      end
   end

   assign busy = (state != IDLE);

   for (genvar l = 0; l < N_IN; l++) begin : lane
      router_port_arbiter_lane #(.GW(GW), .IDX(l)) u_lane (
         .g      (g),
         .busy   (busy),
         .ack    (ack),
         .grant  (grant[l]),
         .in_ack (in_ack[l])
      );
   end
endmodule
